// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Decode-stage register file: two combinational read ports, one synchronous
// write port and a PC override on index PC_IDX. Each implemented register has
// a small saturating counter of outstanding writes. Issue logic increments it
// and writeback decrements it, so decode can spot RAW hazards on its own.
//
// Optional build macro: REGFILE_WR_BYPASS_EN
//   defined   - a same-cycle writeback is forwarded to the read ports, and the
//               pending flag clears in the cycle that retires the last write.
//   undefined - reads show the stored value; pending follows the counters.

module regfile_scoreboard #(
  parameter int SIZE       = 32,
  parameter int AMOUNT_REG = 4,
  parameter int NUM_REGS   = 16,
  parameter int PC_IDX     = 15,
  parameter int CNT_W      = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WE3,
  input  logic [AMOUNT_REG-1:0] RA1,
  input  logic [AMOUNT_REG-1:0] RA2,
  input  logic [AMOUNT_REG-1:0] RA3,
  input  logic [SIZE-1:0]       WD3,
  input  logic [SIZE-1:0]       R15,
  input  logic                  ISSUE,
  input  logic [AMOUNT_REG-1:0] ISSUE_RD,
  input  logic                  FLUSH,
  output logic [SIZE-1:0]       RD1,
  output logic [SIZE-1:0]       RD2,
  output logic                  PEND1,
  output logic                  PEND2,
  output logic                  ISSUE_FULL
);

  localparam logic [AMOUNT_REG-1:0] PC_ADDR = AMOUNT_REG'(PC_IDX);
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  // Storage and outstanding-write counters
  logic [SIZE-1:0]  r_rf  [NUM_REGS];
  logic [CNT_W-1:0] r_cnt [NUM_REGS];

  // Array lookups for each address port
  logic [SIZE-1:0]  w_rd1Arr;
  logic [SIZE-1:0]  w_rd2Arr;
  logic [CNT_W-1:0] w_cnt1;
  logic [CNT_W-1:0] w_cnt2;
  logic [CNT_W-1:0] w_cntWr;
  logic [CNT_W-1:0] w_cntIssue;

  // Qualified control
  logic                w_wrValid;
  logic                w_issueValid;
  logic                w_issueFull;
  logic                w_inc;
  logic                w_dec;
  logic [NUM_REGS-1:0] w_incHit;
  logic [NUM_REGS-1:0] w_decHit;

  // A register is tracked and writable only if implemented and not the PC slot
  function automatic logic isTracked(input logic [AMOUNT_REG-1:0] addr);
    return (int'(addr) < NUM_REGS) && (addr != PC_ADDR);
  endfunction

  // Look up stored data and counters; untracked addresses read as zero
  always_comb begin
    w_rd1Arr   = '0;
    w_rd2Arr   = '0;
    w_cnt1     = '0;
    w_cnt2     = '0;
    w_cntWr    = '0;
    w_cntIssue = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RA1 == AMOUNT_REG'(i)) begin
        w_rd1Arr = r_rf[i];
        if (isTracked(RA1)) w_cnt1 = r_cnt[i];
      end
      if (RA2 == AMOUNT_REG'(i)) begin
        w_rd2Arr = r_rf[i];
        if (isTracked(RA2)) w_cnt2 = r_cnt[i];
      end
      if ((RA3 == AMOUNT_REG'(i)) && isTracked(RA3)) begin
        w_cntWr = r_cnt[i];
      end
      if ((ISSUE_RD == AMOUNT_REG'(i)) && isTracked(ISSUE_RD)) begin
        w_cntIssue = r_cnt[i];
      end
    end
  end

  // Qualify issue and writeback, and decode them to per-register hit vectors
  always_comb begin
    w_wrValid    = WE3 && isTracked(RA3);
    w_issueValid = ISSUE && isTracked(ISSUE_RD);
    w_issueFull  = ISSUE && (w_cntIssue == CNT_MAX);
    w_inc        = w_issueValid && !w_issueFull;
    w_dec        = w_wrValid && (w_cntWr != '0);
    w_incHit     = '0;
    w_decHit     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_incHit[i] = w_inc && (ISSUE_RD == AMOUNT_REG'(i));
      w_decHit[i] = w_dec && (RA3 == AMOUNT_REG'(i));
    end
  end

  // Read port 1: PC override first, then optional forwarding, then storage
  always_comb begin
    RD1   = w_rd1Arr;
    PEND1 = (w_cnt1 != '0);
    if (RA1 == PC_ADDR) begin
      RD1 = R15;
    end
`ifdef REGFILE_WR_BYPASS_EN
    else if (w_wrValid && (RA3 == RA1)) begin
      RD1 = WD3;
      if ((w_cnt1 == CNT_ONE) && !(w_inc && (ISSUE_RD == RA1))) PEND1 = 1'b0;
    end
`endif
  end

  // Read port 2: same structure as port 1
  always_comb begin
    RD2   = w_rd2Arr;
    PEND2 = (w_cnt2 != '0);
    if (RA2 == PC_ADDR) begin
      RD2 = R15;
    end
`ifdef REGFILE_WR_BYPASS_EN
    else if (w_wrValid && (RA3 == RA2)) begin
      RD2 = WD3;
      if ((w_cnt2 == CNT_ONE) && !(w_inc && (ISSUE_RD == RA2))) PEND2 = 1'b0;
    end
`endif
  end

  // Rejection is reported in the same cycle the issue is presented
  assign ISSUE_FULL = w_issueFull;

  // Update storage and counters; a flush clears tracking but keeps the new issue
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wrValid && (RA3 == AMOUNT_REG'(i))) begin
          r_rf[i] <= WD3;
        end
        if (FLUSH) begin
          r_cnt[i] <= w_incHit[i] ? CNT_ONE : '0;
        end else if (w_incHit[i] && !w_decHit[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_decHit[i] && !w_incHit[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Directed checks of regfile_scoreboard with hand-computed expectations.
// Build with REGFILE_WR_BYPASS_EN defined to check the forwarding variant.

module tb_regfile_scoreboard;

  localparam int SIZE       = 32;
  localparam int AMOUNT_REG = 4;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST_N;
  logic                  WE3;
  logic [AMOUNT_REG-1:0] RA1;
  logic [AMOUNT_REG-1:0] RA2;
  logic [AMOUNT_REG-1:0] RA3;
  logic [SIZE-1:0]       WD3;
  logic [SIZE-1:0]       R15;
  logic                  ISSUE;
  logic [AMOUNT_REG-1:0] ISSUE_RD;
  logic                  FLUSH;
  logic [SIZE-1:0]       RD1;
  logic [SIZE-1:0]       RD2;
  logic                  PEND1;
  logic                  PEND2;
  logic                  ISSUE_FULL;

  int nChecks = 0;
  int nFails  = 0;

  regfile_scoreboard dut (
    .CLK(CLK), .RST_N(RST_N), .WE3(WE3), .RA1(RA1), .RA2(RA2), .RA3(RA3),
    .WD3(WD3), .R15(R15), .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD), .FLUSH(FLUSH),
    .RD1(RD1), .RD2(RD2), .PEND1(PEND1), .PEND2(PEND2), .ISSUE_FULL(ISSUE_FULL)
  );

  // Free-running clock, 10 time units per period
  always #5 CLK = ~CLK;

  // Deassert all per-cycle controls
  task automatic idle();
    WE3 = 1'b0; RA3 = '0; WD3 = '0;
    ISSUE = 1'b0; ISSUE_RD = '0; FLUSH = 1'b0;
  endtask

  // Reset with writes/issues present, then sweep all read addresses
  task automatic test_reset();
    logic [SIZE-1:0] exp1;
    logic [SIZE-1:0] exp2;
    @(negedge CLK);
    idle(); RST_N = 1'b0; WE3 = 1'b1; RA3 = 4'd2; WD3 = 32'hFF;
    ISSUE = 1'b1; ISSUE_RD = 4'd3;
    @(negedge CLK);
    idle(); RST_N = 1'b1; R15 = 32'h0000_0108;
    for (int a = 0; a < 16; a++) begin
      RA1 = 4'(a); RA2 = 4'(15 - a);
      #1;
      exp1 = (a == 15) ? 32'h0000_0108 : 32'h0;
      exp2 = (a == 0)  ? 32'h0000_0108 : 32'h0;
      nChecks++;
      if (RD1 !== exp1) begin
        nFails++; $display("[TB] FAIL reset_rd1[%0d]: got %h expected %h", a, RD1, exp1);
      end
      nChecks++;
      if (RD2 !== exp2) begin
        nFails++; $display("[TB] FAIL reset_rd2[%0d]: got %h expected %h", 15 - a, RD2, exp2);
      end
      nChecks++;
      if (PEND1 !== 1'b0) begin
        nFails++; $display("[TB] FAIL reset_pend1[%0d]: got %b expected 0", a, PEND1);
      end
      nChecks++;
      if (PEND2 !== 1'b0) begin
        nFails++; $display("[TB] FAIL reset_pend2[%0d]: got %b expected 0", 15 - a, PEND2);
      end
    end
    nChecks++;
    if (ISSUE_FULL !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_full: got %b expected 0", ISSUE_FULL);
    end
  endtask

  // Basic write, latency, and dropped PC write
  task automatic test_write();
    logic [SIZE-1:0] exp;
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd3; WD3 = 32'hDEAD_BEEF; RA1 = 4'd3;
    #1;
    exp = BYPASS ? 32'hDEAD_BEEF : 32'h0;
    nChecks++;
    if (RD1 !== exp) begin
      nFails++; $display("[TB] FAIL write_cycle_rd1: got %h expected %h", RD1, exp);
    end
    @(negedge CLK);
    idle(); RA1 = 4'd3;
    #1;
    nChecks++;
    if (RD1 !== 32'hDEAD_BEEF) begin
      nFails++; $display("[TB] FAIL write_rd1: got %h expected deadbeef", RD1);
    end
    nChecks++;
    if (PEND1 !== 1'b0) begin
      nFails++; $display("[TB] FAIL write_no_underflow: got %b expected 0", PEND1);
    end
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd15; WD3 = 32'h1; RA2 = 4'd15; R15 = 32'h0000_0108;
    @(negedge CLK);
    idle(); RA2 = 4'd15; R15 = 32'h0000_0200;
    #1;
    nChecks++;
    if (RD2 !== 32'h0000_0200) begin
      nFails++; $display("[TB] FAIL write_pc_rd2: got %h expected 00000200", RD2);
    end
  endtask

  // Saturating counter on r5, then drain by writebacks; PC never tracked
  task automatic test_scoreboard();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      idle(); ISSUE = 1'b1; ISSUE_RD = 4'd5;
      #1;
      nChecks++;
      if (ISSUE_FULL !== 1'b0) begin
        nFails++; $display("[TB] FAIL sb_full_issue%0d: got %b expected 0", k, ISSUE_FULL);
      end
    end
    @(negedge CLK);
    idle(); RA1 = 4'd5; ISSUE = 1'b1; ISSUE_RD = 4'd5;
    #1;
    nChecks++;
    if (ISSUE_FULL !== 1'b1) begin
      nFails++; $display("[TB] FAIL sb_full_4th: got %b expected 1", ISSUE_FULL);
    end
    nChecks++;
    if (PEND1 !== 1'b1) begin
      nFails++; $display("[TB] FAIL sb_pend_at3: got %b expected 1", PEND1);
    end
    @(negedge CLK);
    idle(); RA1 = 4'd5;
    #1;
    nChecks++;
    if (PEND1 !== 1'b1) begin
      nFails++; $display("[TB] FAIL sb_pend_held: got %b expected 1", PEND1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      idle(); WE3 = 1'b1; RA3 = 4'd5; WD3 = 32'h500 + 32'(k);
      @(negedge CLK);
      idle(); RA1 = 4'd5;
      #1;
      nChecks++;
      if (PEND1 !== (k < 2)) begin
        nFails++; $display("[TB] FAIL sb_drain%0d: got %b expected %b", k, PEND1, (k < 2));
      end
    end
    nChecks++;
    if (RD1 !== 32'h502) begin
      nFails++; $display("[TB] FAIL sb_data: got %h expected 00000502", RD1);
    end
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd15; RA2 = 4'd15;
    #1;
    nChecks++;
    if (ISSUE_FULL !== 1'b0) begin
      nFails++; $display("[TB] FAIL sb_pc_full: got %b expected 0", ISSUE_FULL);
    end
    @(negedge CLK);
    idle(); RA2 = 4'd15;
    #1;
    nChecks++;
    if (PEND2 !== 1'b0) begin
      nFails++; $display("[TB] FAIL sb_pc_pend: got %b expected 0", PEND2);
    end
  endtask

  // Simultaneous inc/dec on r7, then retire and writeback at zero
  task automatic test_same_cycle();
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd7;
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd7; WE3 = 1'b1; RA3 = 4'd7; WD3 = 32'h77; RA1 = 4'd7;
    #1;
    nChecks++;
    if (PEND1 !== 1'b1) begin
      nFails++; $display("[TB] FAIL same_incdec_cycle_pend: got %b expected 1", PEND1);
    end
    @(negedge CLK);
    idle(); RA1 = 4'd7;
    #1;
    nChecks++;
    if (PEND1 !== 1'b1) begin
      nFails++; $display("[TB] FAIL same_incdec_pend: got %b expected 1", PEND1);
    end
    nChecks++;
    if (RD1 !== 32'h77) begin
      nFails++; $display("[TB] FAIL same_incdec_data: got %h expected 00000077", RD1);
    end
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd7; WD3 = 32'h78; RA1 = 4'd7;
    #1;
    nChecks++;
    if (PEND1 !== !BYPASS) begin
      nFails++; $display("[TB] FAIL same_retire_cycle_pend: got %b expected %b", PEND1, !BYPASS);
    end
    @(negedge CLK);
    idle(); RA1 = 4'd7;
    #1;
    nChecks++;
    if (PEND1 !== 1'b0) begin
      nFails++; $display("[TB] FAIL same_retire_pend: got %b expected 0", PEND1);
    end
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd7; WD3 = 32'h79;
    @(negedge CLK);
    idle(); RA1 = 4'd7;
    #1;
    nChecks++;
    if (PEND1 !== 1'b0) begin
      nFails++; $display("[TB] FAIL same_underflow_pend: got %b expected 0", PEND1);
    end
    nChecks++;
    if (RD1 !== 32'h79) begin
      nFails++; $display("[TB] FAIL same_zero_wb_data: got %h expected 00000079", RD1);
    end
  endtask

  // Flush clears r2 (cnt 2) and r4 (cnt 1), keeps the same-cycle issue of r9
  task automatic test_flush();
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd2;
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd2;
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd4;
    @(negedge CLK);
    idle(); RA1 = 4'd2; RA2 = 4'd4;
    #1;
    nChecks++;
    if ((PEND1 !== 1'b1) || (PEND2 !== 1'b1)) begin
      nFails++; $display("[TB] FAIL flush_pre_pend: got %b%b expected 11", PEND1, PEND2);
    end
    @(negedge CLK);
    idle(); FLUSH = 1'b1; ISSUE = 1'b1; ISSUE_RD = 4'd9;
    WE3 = 1'b1; RA3 = 4'd2; WD3 = 32'h22; RA1 = 4'd0; RA2 = 4'd0;
    @(negedge CLK);
    idle(); RA1 = 4'd2; RA2 = 4'd4;
    #1;
    nChecks++;
    if (PEND1 !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_pend_r2: got %b expected 0", PEND1);
    end
    nChecks++;
    if (PEND2 !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_pend_r4: got %b expected 0", PEND2);
    end
    nChecks++;
    if (RD1 !== 32'h22) begin
      nFails++; $display("[TB] FAIL flush_data_r2: got %h expected 00000022", RD1);
    end
    RA1 = 4'd9;
    #1;
    nChecks++;
    if (PEND1 !== 1'b1) begin
      nFails++; $display("[TB] FAIL flush_pend_r9: got %b expected 1", PEND1);
    end
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd9; WD3 = 32'h9;
    @(negedge CLK);
    idle(); RA1 = 4'd9;
    #1;
    nChecks++;
    if (PEND1 !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_r9_drain: got %b expected 0", PEND1);
    end
  endtask

  // Reset asserted mid-operation with a write and issue on r6 (cnt 2)
  task automatic test_reset_mid();
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd6;
    @(negedge CLK);
    idle(); ISSUE = 1'b1; ISSUE_RD = 4'd6;
    @(negedge CLK);
    idle(); RA1 = 4'd6;
    #1;
    nChecks++;
    if (PEND1 !== 1'b1) begin
      nFails++; $display("[TB] FAIL midrst_pre_pend: got %b expected 1", PEND1);
    end
    @(negedge CLK);
    idle(); RST_N = 1'b0; WE3 = 1'b1; RA3 = 4'd6; WD3 = 32'hABC;
    ISSUE = 1'b1; ISSUE_RD = 4'd6;
    @(negedge CLK);
    idle(); RST_N = 1'b1; RA1 = 4'd6; RA2 = 4'd3;
    #1;
    nChecks++;
    if (RD1 !== 32'h0) begin
      nFails++; $display("[TB] FAIL midrst_rd_r6: got %h expected 00000000", RD1);
    end
    nChecks++;
    if (PEND1 !== 1'b0) begin
      nFails++; $display("[TB] FAIL midrst_pend_r6: got %b expected 0", PEND1);
    end
    nChecks++;
    if (RD2 !== 32'h0) begin
      nFails++; $display("[TB] FAIL midrst_rd_r3: got %h expected 00000000", RD2);
    end
  endtask

  // Same-cycle forwarding (or its absence) and PC priority over forwarding
  task automatic test_bypass();
    logic [SIZE-1:0] exp;
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd1; WD3 = 32'h55; RA1 = 4'd1; RA2 = 4'd15; R15 = 32'h300;
    #1;
    exp = BYPASS ? 32'h55 : 32'h0;
    nChecks++;
    if (RD1 !== exp) begin
      nFails++; $display("[TB] FAIL bypass_rd1: got %h expected %h", RD1, exp);
    end
    nChecks++;
    if (RD2 !== 32'h300) begin
      nFails++; $display("[TB] FAIL bypass_pc_rd2: got %h expected 00000300", RD2);
    end
    @(negedge CLK);
    idle(); RA1 = 4'd1;
    #1;
    nChecks++;
    if (RD1 !== 32'h55) begin
      nFails++; $display("[TB] FAIL bypass_after: got %h expected 00000055", RD1);
    end
    @(negedge CLK);
    idle(); WE3 = 1'b1; RA3 = 4'd15; WD3 = 32'h99; RA1 = 4'd15;
    #1;
    nChecks++;
    if (RD1 !== 32'h300) begin
      nFails++; $display("[TB] FAIL bypass_pc_write: got %h expected 00000300", RD1);
    end
  endtask

  // Sequence all scenarios, then report
  initial begin
    RST_N = 1'b0; RA1 = '0; RA2 = '0; R15 = '0;
    idle();
    test_reset();
    test_write();
    test_scoreboard();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline register file: 2 async read ports, 1 sync write port, PC override on a configurable index.
- Adds synchronous active-low reset that clears the array.
- Adds a per-register outstanding-write scoreboard so decode can detect RAW hazards without external tracking.
- Sits in the decode stage; writeback drives the write port, issue logic drives the scoreboard.

Parameters:
- SIZE, 32, data width in bits.
- AMOUNT_REG, 4, register address width.
- NUM_REGS, 16, implemented registers; must be <= 2**AMOUNT_REG.
- PC_IDX, 15, index whose reads return R15; never stored or tracked.
- CNT_W, 2, width of each per-register outstanding-write counter.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- WE3  input  1  writeback enable.
- RA1  input  AMOUNT_REG  read address, port 1.
- RA2  input  AMOUNT_REG  read address, port 2.
- RA3  input  AMOUNT_REG  writeback address.
- WD3  input  SIZE  writeback data.
- R15  input  SIZE  PC value returned for reads of PC_IDX.
- ISSUE  input  1  instruction with destination issued this cycle.
- ISSUE_RD  input  AMOUNT_REG  destination register of issued instruction.
- FLUSH  input  1  pipeline flush; discards all outstanding-write tracking.
- RD1  output  SIZE  read data, port 1.
- RD2  output  SIZE  read data, port 2.
- PEND1  output  1  RA1 has an outstanding write.
- PEND2  output  1  RA2 has an outstanding write.
- ISSUE_FULL  output  1  ISSUE_RD counter saturated; issue rejected.

Behaviour:
- Reset (RST_N low at edge): every register <= 0, every counter <= 0. WE3, ISSUE and FLUSH are ignored that cycle.
- After reset: RD1/RD2 = 0 (except PC_IDX, which returns R15). PEND1, PEND2 and ISSUE_FULL = 0.
- Reads: combinational, zero latency.
  - RDx = R15 when RAx == PC_IDX; otherwise the array entry.
  - RAx >= NUM_REGS reads 0.
- Write: on edge with WE3=1, RA3 < NUM_REGS and RA3 != PC_IDX, rf[RA3] <= WD3. New data is visible on RDx in the following cycle.
  - Writes to PC_IDX or to out-of-range addresses are dropped.
- Scoreboard: one CNT_W-bit counter cnt[i] per register.
  - Issue increment (inc) = ISSUE && ISSUE_RD valid && ISSUE_RD != PC_IDX && !ISSUE_FULL.
  - Writeback decrement (dec) = WE3 && RA3 valid && RA3 != PC_IDX && cnt[RA3] != 0.
  - inc and dec to the same register in the same cycle: counter unchanged.
  - dec at 0: no underflow; data is still written.
  - ISSUE_FULL = ISSUE && cnt[ISSUE_RD] == 2**CNT_W-1 (combinational). Counter is held, not wrapped.
- FLUSH: every counter is cleared, then the same-cycle inc is applied (that register ends at 1). A same-cycle write still updates data.
- PENDx = (cnt[RAx] != 0), combinational. Always 0 for PC_IDX and for out-of-range addresses.
- Mid-operation reset behaves as the reset bullet; there is no other state.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - Write-through forwarding: when WE3=1, RA3 == RAx, and RA3 is valid and != PC_IDX, RDx = WD3 in the same cycle.
  - PENDx is also suppressed in that cycle when cnt[RAx] == 1 and no same-cycle inc targets RAx.
- Undefined:
  - RDx shows the old array value during the write cycle.
  - PENDx follows the registered counter only.

Test Plan:
- Reset, then read all 16 addresses -> RD = 0 for r0..r14; RA=15 with R15=0x00000108 -> RD=0x00000108; PEND1=PEND2=0.
- WE3=1, RA3=3, WD3=0xDEADBEEF; next cycle RA1=3 -> RD1=0xDEADBEEF. WE3=1, RA3=15, WD3=0x1 -> RA2=15 still returns R15.
- ISSUE r5 three times (CNT_W=2) -> PEND1=1 for RA1=5. Fourth ISSUE r5 -> ISSUE_FULL=1, counter stays 3. Three writebacks to r5 -> PEND1=0 after the third edge.
- Same cycle ISSUE r7 and WE3 r7 with cnt=1 -> cnt stays 1, PEND1 remains 1. Writeback r7 at cnt=0 -> data written, no underflow.
- ISSUE r2,r4; then FLUSH with ISSUE r9 -> next cycle PEND for r2/r4 = 0, PEND for r9 = 1.
- RST_N=0 asserted while cnt[r6]=2 and WE3 active -> next cycle r6 reads 0, PEND=0. With REGFILE_WR_BYPASS_EN, WE3 r1=0x55 with RA1=1 -> RD1=0x55 in the same cycle.
